// File: rtl/decode_stage_if.sv
// Decode-stage port bundle: IF/ID and write-back inputs, plus the ID/EX register outputs.
interface decode_stage_if #(
  parameter int XLEN       = 8,
  parameter int REG_ADDR_W = 5
);
  logic                  if_valid;
  logic [31:0]           instruction;
  logic                  flush;
  logic                  wb_reg_write;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic                  stall;
  logic                  ex_valid;
  logic                  ex_branch;
  logic                  ex_mem_read;
  logic                  ex_mem_to_reg;
  logic                  ex_mem_write;
  logic                  ex_alu_src;
  logic                  ex_reg_write;
  logic [1:0]            ex_alu_op;
  logic                  ex_illegal;
  logic [XLEN-1:0]       ex_read_data1;
  logic [XLEN-1:0]       ex_read_data2;
  logic [11:0]           ex_immediate;
  logic [XLEN-1:0]       ex_imm_sext;
  logic [6:0]            ex_funct7;
  logic [2:0]            ex_funct3;
  logic [REG_ADDR_W-1:0] ex_rs1;
  logic [REG_ADDR_W-1:0] ex_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;

  modport master (
    output if_valid, instruction, flush, wb_reg_write, wb_rd, wb_data,
    input  stall, ex_valid, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write,
           ex_alu_src, ex_reg_write, ex_alu_op, ex_illegal, ex_read_data1,
           ex_read_data2, ex_immediate, ex_imm_sext, ex_funct7, ex_funct3,
           ex_rs1, ex_rs2, ex_rd
  );

  modport slave (
    input  if_valid, instruction, flush, wb_reg_write, wb_rd, wb_data,
    output stall, ex_valid, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write,
           ex_alu_src, ex_reg_write, ex_alu_op, ex_illegal, ex_read_data1,
           ex_read_data2, ex_immediate, ex_imm_sext, ex_funct7, ex_funct3,
           ex_rs1, ex_rs2, ex_rd
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode: control decode, register file with WB bypass, immediate
// generation, load-use stall detection and the ID/EX pipeline register.
module decode_stage #(
  parameter int XLEN       = 8,
  parameter int REG_ADDR_W = 5
) (
  input logic           clock,
  input logic           reset,
  decode_stage_if.slave bus
);
  localparam int NREG = 2 ** REG_ADDR_W;
  localparam int SW   = (XLEN > 12) ? XLEN : 12;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef struct packed {
    logic                  valid;
    logic                  branch;
    logic                  mem_read;
    logic                  mem_to_reg;
    logic                  mem_write;
    logic                  alu_src;
    logic                  reg_write;
    logic [1:0]            alu_op;
    logic                  illegal;
    logic [XLEN-1:0]       read_data1;
    logic [XLEN-1:0]       read_data2;
    logic [11:0]           immediate;
    logic [XLEN-1:0]       imm_sext;
    logic [6:0]            funct7;
    logic [2:0]            funct3;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
  } id_ex_t;

  logic [XLEN-1:0]       regs [NREG];
  logic [6:0]            opcode;
  logic [REG_ADDR_W-1:0] rs1, rs2, rd;
  logic                  uses_rs1, uses_rs2;
  logic [11:0]           imm;
  logic signed [11:0]    imm_s;
  logic [SW-1:0]         sext_full;
  logic [XLEN-1:0]       rd1, rd2;
  logic                  stall;
  id_ex_t                ex_d, ex_q;

  assign opcode = bus.instruction[6:0];
  assign rs1    = REG_ADDR_W'(bus.instruction[19:15]);
  assign rs2    = REG_ADDR_W'(bus.instruction[24:20]);
  assign rd     = REG_ADDR_W'(bus.instruction[11:7]);

  // x0 is hard-wired; a same-cycle write-back wins over the stored value
  assign rd1 = (rs1 == '0) ? '0 :
               (bus.wb_reg_write && bus.wb_rd == rs1) ? bus.wb_data : regs[rs1];
  assign rd2 = (rs2 == '0) ? '0 :
               (bus.wb_reg_write && bus.wb_rd == rs2) ? bus.wb_data : regs[rs2];

  assign imm_s     = imm;
  assign sext_full = SW'(imm_s);

  always_comb begin
    ex_d            = '0;
    uses_rs1        = 1'b0;
    uses_rs2        = 1'b0;
    imm             = '0;
    case (opcode)
      OP_R: begin
        ex_d.reg_write = 1'b1;
        ex_d.alu_op    = 2'b10;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
      end
      OP_I: begin
        ex_d.alu_src   = 1'b1;
        ex_d.reg_write = 1'b1;
        ex_d.alu_op    = 2'b11;
        uses_rs1       = 1'b1;
        imm            = bus.instruction[31:20];
      end
      OP_LD: begin
        ex_d.alu_src    = 1'b1;
        ex_d.mem_to_reg = 1'b1;
        ex_d.reg_write  = 1'b1;
        ex_d.mem_read   = 1'b1;
        uses_rs1        = 1'b1;
        imm             = bus.instruction[31:20];
      end
      OP_ST: begin
        ex_d.alu_src   = 1'b1;
        ex_d.mem_write = 1'b1;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
        imm            = {bus.instruction[31:25], bus.instruction[11:7]};
      end
      OP_BR: begin
        ex_d.branch = 1'b1;
        ex_d.alu_op = 2'b01;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        imm         = {bus.instruction[31], bus.instruction[7],
                       bus.instruction[30:25], bus.instruction[11:8]};
      end
      default: ex_d.illegal = 1'b1;
    endcase
    ex_d.valid      = 1'b1;
    ex_d.read_data1 = rd1;
    ex_d.read_data2 = rd2;
    ex_d.immediate  = imm;
    ex_d.imm_sext   = sext_full[XLEN-1:0];
    ex_d.funct7     = bus.instruction[31:25];
    ex_d.funct3     = bus.instruction[14:12];
    ex_d.rs1        = rs1;
    ex_d.rs2        = rs2;
    ex_d.rd         = rd;
  end

  assign stall = bus.if_valid && !bus.flush && ex_q.valid && ex_q.mem_read &&
                 (ex_q.rd != '0) &&
                 ((uses_rs1 && ex_q.rd == rs1) || (uses_rs2 && ex_q.rd == rs2));

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      ex_q <= '0;
    end else begin
      if (bus.wb_reg_write && bus.wb_rd != '0) regs[bus.wb_rd] <= bus.wb_data;
      // flush, stall and an empty IF/ID slot all insert a fully zeroed bubble
      if (bus.flush || stall || !bus.if_valid) ex_q <= '0;
      else                                      ex_q <= ex_d;
    end
  end

  assign bus.stall         = stall;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_branch     = ex_q.branch;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_alu_src    = ex_q.alu_src;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_alu_op     = ex_q.alu_op;
  assign bus.ex_illegal    = ex_q.illegal;
  assign bus.ex_read_data1 = ex_q.read_data1;
  assign bus.ex_read_data2 = ex_q.read_data2;
  assign bus.ex_immediate  = ex_q.immediate;
  assign bus.ex_imm_sext   = ex_q.imm_sext;
  assign bus.ex_funct7     = ex_q.funct7;
  assign bus.ex_funct3     = ex_q.funct3;
  assign bus.ex_rs1        = ex_q.rs1;
  assign bus.ex_rs2        = ex_q.rs2;
  assign bus.ex_rd         = ex_q.rd;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors push expectations, a monitor checks them.
module tb_decode_stage;
  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  decode_stage_if #(.XLEN(8),  .REG_ADDR_W(5)) bus ();
  decode_stage_if #(.XLEN(16), .REG_ADDR_W(5)) bus16 ();

  decode_stage #(.XLEN(8),  .REG_ADDR_W(5)) dut   (.clock(clock), .reset(reset), .bus(bus.slave));
  decode_stage #(.XLEN(16), .REG_ADDR_W(5)) dut16 (.clock(clock), .reset(reset), .bus(bus16.slave));

  typedef struct packed {
    logic       valid;
    logic       branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic [1:0] alu_op;
    logic       illegal;
    logic [7:0] rd1, rd2;
    logic [11:0] imm;
    logic [7:0] sext;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] rs1, rs2, rd;
  } ex_t;

  typedef struct {
    int          id;
    logic        stall;
    ex_t         ex;
    logic [15:0] s16;
  } sb_t;

  localparam ex_t BUB = '0;
  // control bits: branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, illegal
  localparam logic [6:0] C_R   = 7'b0000010;
  localparam logic [6:0] C_I   = 7'b0000110;
  localparam logic [6:0] C_LD  = 7'b0110110;
  localparam logic [6:0] C_ST  = 7'b0001100;
  localparam logic [6:0] C_BR  = 7'b1000000;
  localparam logic [6:0] C_ILL = 7'b0000001;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  sb_t q[$];
  int  total = 0;
  int  bad   = 0;
  bit  busy  = 0;

  function automatic logic [31:0] ins(input logic [6:0] f7, input logic [4:0] s2, s1,
                                      input logic [2:0] f3, input logic [4:0] d,
                                      input logic [6:0] op);
    return {f7, s2, s1, f3, d, op};
  endfunction

  function automatic ex_t mk(input logic [6:0] c, input logic [1:0] op,
                             input logic [7:0] d1, d2, input logic [11:0] imm,
                             input logic [6:0] f7, input logic [2:0] f3,
                             input logic [4:0] s1, s2, d);
    ex_t r;
    r       = '0;
    r.valid = 1'b1;
    {r.branch, r.mem_read, r.mem_to_reg, r.mem_write, r.alu_src, r.reg_write, r.illegal} = c;
    r.alu_op = op;
    r.rd1    = d1;
    r.rd2    = d2;
    r.imm    = imm;
    r.sext   = imm[7:0];
    r.f7     = f7;
    r.f3     = f3;
    r.rs1    = s1;
    r.rs2    = s2;
    r.rd     = d;
    return r;
  endfunction

  task automatic cyc(input int id, input logic rst, iv, input logic [31:0] instr,
                     input logic fl, wbw, input logic [4:0] wrd, input logic [7:0] wd,
                     input logic est, input ex_t ex, input logic [15:0] s16);
    sb_t e;
    @(negedge clock);
    reset              = rst;
    bus.if_valid       = iv;   bus16.if_valid     = iv;
    bus.instruction    = instr; bus16.instruction = instr;
    bus.flush          = fl;   bus16.flush        = fl;
    bus.wb_reg_write   = wbw;  bus16.wb_reg_write = wbw;
    bus.wb_rd          = wrd;  bus16.wb_rd        = wrd;
    bus.wb_data        = wd;   bus16.wb_data      = {8'h00, wd};
    e.id = id; e.stall = est; e.ex = ex; e.s16 = s16;
    q.push_back(e);
  endtask

  initial begin : monitor
    sb_t e;
    ex_t act;
    forever begin
      @(negedge clock);
      #2;
      if (q.size() != 0) begin
        e    = q.pop_front();
        busy = 1'b1;
        total++;
        if (bus.stall !== e.stall) begin
          bad++;
          $display("FAIL stall step %0d: got %b want %b", e.id, bus.stall, e.stall);
        end
        @(posedge clock);
        #1;
        act = '0;
        act.valid = bus.ex_valid;
        act.branch = bus.ex_branch;       act.mem_read  = bus.ex_mem_read;
        act.mem_to_reg = bus.ex_mem_to_reg; act.mem_write = bus.ex_mem_write;
        act.alu_src = bus.ex_alu_src;     act.reg_write = bus.ex_reg_write;
        act.alu_op = bus.ex_alu_op;       act.illegal   = bus.ex_illegal;
        act.rd1 = bus.ex_read_data1;      act.rd2       = bus.ex_read_data2;
        act.imm = bus.ex_immediate;       act.sext      = bus.ex_imm_sext;
        act.f7 = bus.ex_funct7;           act.f3        = bus.ex_funct3;
        act.rs1 = bus.ex_rs1;             act.rs2       = bus.ex_rs2;
        act.rd = bus.ex_rd;
        total++;
        if (act !== e.ex) begin
          bad++;
          $display("FAIL id_ex step %0d: got %h want %h", e.id, act, e.ex);
        end
        total++;
        if (bus16.ex_imm_sext !== e.s16) begin
          bad++;
          $display("FAIL imm_sext16 step %0d: got %h want %h", e.id, bus16.ex_imm_sext, e.s16);
        end
        busy = 1'b0;
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1;
    bus.if_valid = 0;   bus16.if_valid = 0;
    bus.instruction = 0; bus16.instruction = 0;
    bus.flush = 0;      bus16.flush = 0;
    bus.wb_reg_write = 0; bus16.wb_reg_write = 0;
    bus.wb_rd = 0;      bus16.wb_rd = 0;
    bus.wb_data = 0;    bus16.wb_data = 0;
    repeat (2) @(posedge clock);

    cyc(0,  1, 0, 32'h0, 0, 0, 0, 8'h00, 0, BUB, 16'h0);
    cyc(1,  0, 0, 32'h0, 0, 1, 1, 8'h05, 0, BUB, 16'h0);
    cyc(2,  0, 0, 32'h0, 0, 1, 2, 8'h07, 0, BUB, 16'h0);
    // add x3,x1,x2
    cyc(3,  0, 1, ins(7'h00, 2, 1, 0, 3, OP_R), 0, 0, 0, 8'h00, 0,
        mk(C_R, 2'b10, 8'h05, 8'h07, 12'h000, 7'h00, 3'd0, 1, 2, 3), 16'h0000);
    // addi x7,x1,-1
    cyc(4,  0, 1, ins(7'h7F, 31, 1, 0, 7, OP_I), 0, 0, 0, 8'h00, 0,
        mk(C_I, 2'b11, 8'h05, 8'h00, 12'hFFF, 7'h7F, 3'd0, 1, 31, 7), 16'hFFFF);
    // lw x4,3(x2)
    cyc(5,  0, 1, ins(7'h00, 3, 2, 2, 4, OP_LD), 0, 0, 0, 8'h00, 0,
        mk(C_LD, 2'b00, 8'h07, 8'h00, 12'h003, 7'h00, 3'd2, 2, 3, 4), 16'h0003);
    // add x5,x4,x1: load-use stall, then issue with loaded value bypassed from WB
    cyc(6,  0, 1, ins(7'h00, 1, 4, 0, 5, OP_R), 0, 0, 0, 8'h00, 1, BUB, 16'h0);
    cyc(7,  0, 1, ins(7'h00, 1, 4, 0, 5, OP_R), 0, 1, 4, 8'h11, 0,
        mk(C_R, 2'b10, 8'h11, 8'h05, 12'h000, 7'h00, 3'd0, 4, 1, 5), 16'h0000);
    // lw x0,0(x1) then add x5,x0,x1 with a WB to x0: no stall, x0 reads 0
    cyc(8,  0, 1, ins(7'h00, 0, 1, 2, 0, OP_LD), 0, 0, 0, 8'h00, 0,
        mk(C_LD, 2'b00, 8'h05, 8'h00, 12'h000, 7'h00, 3'd2, 1, 0, 0), 16'h0000);
    cyc(9,  0, 1, ins(7'h00, 1, 0, 0, 5, OP_R), 0, 1, 0, 8'h99, 0,
        mk(C_R, 2'b10, 8'h00, 8'h05, 12'h000, 7'h00, 3'd0, 0, 1, 5), 16'h0000);
    // add x8,x6,x2 while WB writes x6=0x3C
    cyc(10, 0, 1, ins(7'h00, 2, 6, 0, 8, OP_R), 0, 1, 6, 8'h3C, 0,
        mk(C_R, 2'b10, 8'h3C, 8'h07, 12'h000, 7'h00, 3'd0, 6, 2, 8), 16'h0000);
    // sw x6,-91(x2): imm 0xFA5
    cyc(11, 0, 1, ins(7'h7D, 6, 2, 2, 5, OP_ST), 0, 0, 0, 8'h00, 0,
        mk(C_ST, 2'b00, 8'h07, 8'h3C, 12'hFA5, 7'h7D, 3'd2, 2, 6, 5), 16'hFFA5);
    // beq x1,x2: imm 0x424
    cyc(12, 0, 1, ins(7'h02, 2, 1, 0, 9, OP_BR), 0, 0, 0, 8'h00, 0,
        mk(C_BR, 2'b01, 8'h05, 8'h07, 12'h424, 7'h02, 3'd0, 1, 2, 9), 16'h0424);
    // unrecognised opcode 0x7F
    cyc(13, 0, 1, ins(7'h00, 2, 1, 0, 3, 7'h7F), 0, 0, 0, 8'h00, 0,
        mk(C_ILL, 2'b00, 8'h05, 8'h07, 12'h000, 7'h00, 3'd0, 1, 2, 3), 16'h0000);
    // lw x10 then dependent add under flush
    cyc(14, 0, 1, ins(7'h00, 0, 1, 2, 10, OP_LD), 0, 0, 0, 8'h00, 0,
        mk(C_LD, 2'b00, 8'h05, 8'h00, 12'h000, 7'h00, 3'd2, 1, 0, 10), 16'h0000);
    cyc(15, 0, 1, ins(7'h00, 2, 10, 0, 11, OP_R), 1, 0, 0, 8'h00, 0, BUB, 16'h0);
    cyc(16, 0, 0, ins(7'h00, 2, 10, 0, 11, OP_R), 0, 0, 0, 8'h00, 0, BUB, 16'h0);
    // lw x12 then dependent add with reset asserted during the stall
    cyc(17, 0, 1, ins(7'h00, 0, 2, 2, 12, OP_LD), 0, 0, 0, 8'h00, 0,
        mk(C_LD, 2'b00, 8'h07, 8'h00, 12'h000, 7'h00, 3'd2, 2, 0, 12), 16'h0000);
    cyc(18, 1, 1, ins(7'h00, 0, 12, 0, 13, OP_R), 0, 0, 0, 8'h00, 1, BUB, 16'h0);
    // registers cleared by reset: x1 and x2 now read 0
    cyc(19, 0, 1, ins(7'h00, 2, 1, 0, 14, OP_R), 0, 0, 0, 8'h00, 0,
        mk(C_R, 2'b10, 8'h00, 8'h00, 12'h000, 7'h00, 3'd0, 1, 2, 14), 16'h0000);
    cyc(20, 0, 0, 32'h0, 0, 0, 0, 8'h00, 0, BUB, 16'h0);

    for (int i = 0; i < 50 && (q.size() != 0 || busy); i++) @(negedge clock);
    if (q.size() != 0 || busy) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised instruction-decode stage for the RISC-V pipeline core: decodes a 32-bit instruction, reads a register file with write-back bypass, generates the immediate, detects load-use hazards, and registers all results into an ID/EX pipeline register with valid/bubble semantics. It sits between the IF/ID register and the execute stage. It supersedes the unregistered decode path by adding configurable data width, the I-type ALU class, stall/flush control and the pipeline register.

## Interface
- XLEN, 8, register/data width in bits (≥1)
- REG_ADDR_W, 5, register address width; register count = 2**REG_ADDR_W; instruction fields truncated to low REG_ADDR_W bits

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- if_valid  in  1  instruction from IF/ID is valid
- instruction  in  32  instruction word
- flush  in  1  squash instruction entering ID/EX (taken branch in EX)
- wb_reg_write  in  1  write-back enable
- wb_rd  in  REG_ADDR_W  write-back destination
- wb_data  in  XLEN  write-back data
- stall  out  1  combinational; hold PC and IF/ID this cycle
- ex_valid  out  1  ID/EX holds a real instruction
- ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write  out  1 each  registered controls
- ex_alu_op  out  2  registered ALU op class
- ex_illegal  out  1  registered; opcode not recognised
- ex_read_data1, ex_read_data2  out  XLEN  registered operands
- ex_immediate  out  12  raw immediate
- ex_imm_sext  out  XLEN  low XLEN bits of sign-extended immediate
- ex_funct7  out  7;  ex_funct3  out  3
- ex_rs1, ex_rs2, ex_rd  out  REG_ADDR_W each  (for forwarding unit)

## Operation
- Decode (opcode → alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op):
  - 0110011 R: 0,0,1,0,0,0,10; uses rs1, rs2
  - 0010011 I-ALU: 1,0,1,0,0,0,11; uses rs1
  - 0000011 load: 1,1,1,1,0,0,00; uses rs1
  - 0100011 store: 1,0,0,0,1,0,00; uses rs1, rs2
  - 1100011 branch: 0,0,0,0,0,1,01; uses rs1, rs2
  - other: all controls 0, illegal=1, uses neither
- Immediate: I/load {i[31:20]}; store {i[31:25],i[11:7]}; branch {i[31],i[7],i[30:25],i[11:8]}; R/illegal 0. ex_imm_sext = sign-extend to max(XLEN,12), keep low XLEN bits.
- Register file: 2**REG_ADDR_W × XLEN; entry 0 reads 0, never written. Write on clock edge when wb_reg_write && wb_rd≠0. Read bypass: rs≠0 && wb_reg_write && wb_rd==rs → read wb_data same cycle.
- Load-use hazard: stall = if_valid && !flush && ex_valid && ex_mem_read && ex_rd≠0 && ((uses_rs1 && ex_rd==rs1) || (uses_rs2 && ex_rd==rs2)).
- ID/EX update priority per edge: reset > flush > stall > !if_valid > load decoded instruction.
- Bubble (reset, flush, stall, !if_valid): every ex_* output = 0, including data and index fields.

## Timing
- Reset: all ex_* = 0, all registers = 0; stall combinationally 0 while ex_valid=0.
- Latency 1 cycle: instruction at edge N appears on ex_* after edge N.
- Stall lasts exactly one cycle per load-use pair: the bubble clears ex_valid, so stall drops next cycle and the held instruction is decoded with the loaded value (via forwarding or WB bypass).
- flush and stall same cycle: flush wins, stall=0, bubble inserted.
- WB write and read of same register same cycle: new value captured into ex_read_data.
- Reset mid-stall: next cycle ex_valid=0, stall=0; register contents cleared.

## Test plan
- Reset, then R-type add x3,x1,x2 with x1=5, x2=7 preloaded via WB → ex_valid=1, reg_write=1, alu_op=10, ex_read_data1=5, ex_read_data2=7, ex_rd=3.
- I-ALU imm 0xFFF, XLEN=8 → ex_immediate=0xFFF, ex_imm_sext=0xFF, alu_src=1, alu_op=11; XLEN=16 → 0xFFFF.
- ld x4 then add x5,x4,x1 back-to-back → stall=1 one cycle, ex_valid=0 bubble, next cycle add issues, stall=0; repeat with rd=x0 → no stall.
- WB write x6=0x3C same cycle as decoding use of x6 → ex_read_data1=0x3C; WB to x0 → x0 reads 0.
- flush asserted with pending load-use → stall=0, ex_valid=0, all controls 0.
- Opcode 0x7F → ex_illegal=1, all controls 0; reset asserted during stall → all ex_* 0 next cycle.
